htd_rr_arbiter: RTL and testbench
=================================

# htd_rr_arbiter

Packet-level round-robin arbiter that shares one head/tail-delimited (htd-framed) output channel among NUM_PORTS requesters. Each requester drives (DATA_WIDTH+1)-bit framed beats in which bit DATA_WIDTH marks the head and tail beats. The arbiter grants one port at a time, forwards that port's packet with one registered cycle of latency, and releases the grant on the tail beat. It sits between several htd framers and a single downstream framed sink.

## Interface
- NUM_PORTS, 4, number of requesters (2..8)
- DATA_WIDTH, 8, payload width; framed beat width is DATA_WIDTH+1
- TIMEOUT_CYCLES, 16, cycles a granted port may wait before sending its head (only with ARB_TIMEOUT_EN)
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous, active-low reset
- iv_req  input  NUM_PORTS  per-port request level
- ov_gnt  output  NUM_PORTS  one-hot grant, registered
- iv_data  input  NUM_PORTS*(DATA_WIDTH+1)  flattened framed beats; port k occupies bits [k*(DATA_WIDTH+1) +: DATA_WIDTH+1]
- iv_data_wr  input  NUM_PORTS  per-port beat valid
- ov_data  output  DATA_WIDTH+1  forwarded framed beat
- o_data_wr  output  1  forwarded beat valid
- o_err  output  1  one-cycle pulse on a protocol violation
- o_timeout  output  1  one-cycle pulse when a grant is revoked by timeout

## Operation
- Reset: ov_gnt=0, ov_data=0, o_data_wr=0, o_err=0, o_timeout=0, state IDLE, round-robin pointer=NUM_PORTS-1 (port 0 has first priority).
- Framing: a packet is at least 2 beats. The first beat with bit DATA_WIDTH=1 is the head, the next beat with bit DATA_WIDTH=1 is the tail, and beats in between have bit DATA_WIDTH=0.
- State IDLE: iv_req is sampled. Winner = first asserted port searching from pointer+1 upward, with wrap-around. On a winner: ov_gnt is set to that port's one-hot value, pointer is set to the winner, next state is WAIT_HEAD. With no request: stay in IDLE.
- State WAIT_HEAD: the granted port's beat with wr=1 and flag=1 is forwarded and the state moves to BODY. A granted beat with flag=0 is dropped and o_err pulses; state is unchanged.
- State BODY: every granted beat is forwarded. A beat with flag=1 is the tail; it is forwarded, ov_gnt clears on the same edge, and the state returns to IDLE.
- Any wr from a non-granted port, in any state, is dropped and o_err pulses. iv_req is ignored outside IDLE; dropping req mid-packet does not revoke the grant.
- Simultaneous events: a granted tail beat and a foreign wr in the same cycle forward the tail and pulse o_err. When several requests arrive in the same IDLE cycle, exactly one port is granted, chosen by the pointer order.

## Timing
- Grant latency: ov_gnt rises on the edge after iv_req is seen in IDLE, so the minimum is 1 cycle from a req assertion registered in IDLE.
- Data latency: ov_data and o_data_wr are exactly 1 cycle behind the granted input beat. o_data_wr=0 and ov_data holds its previous value when nothing is forwarded.
- ov_gnt drops on the edge that registers the tail, which is the same edge on which the tail appears on ov_data.
- Next packet: IDLE takes one cycle, so there is a minimum 1-cycle gap on o_data_wr between packets.
- Back-to-back: the last winner has the lowest priority in the next arbitration.
- An asynchronous reset mid-packet aborts immediately and all outputs go to their reset values. A partial packet is not completed downstream; the sink discards it.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A counter clears on grant and increments each cycle in WAIT_HEAD.
  - When the counter reaches TIMEOUT_CYCLES without a head, ov_gnt clears, o_timeout pulses, and the state returns to IDLE.
  - The pointer stays at the timed-out port, so that port gets lowest priority.
  - BODY is not timed.
- ARB_TIMEOUT_EN undefined: no counter is built, WAIT_HEAD waits indefinitely, and o_timeout is tied to 0.

## Test plan
- Single port, 4-beat packet: port 1 sends beats 0x1A5, 0x011, 0x022, 0x1B6. Required: ov_gnt=4'b0010 one cycle after req, ov_data repeats the same 4 beats 1 cycle late, and ov_gnt=0 after the tail.
- Fairness: all 4 ports hold req, each sending 2-beat packets. Required: grant order is 0,1,2,3,0, with exactly one idle cycle between packets.
- Protocol errors:
  - Port 2 sends a beat while port 0 is granted. Required: the beat is not forwarded and o_err pulses for 1 cycle.
  - The granted port sends a flag=0 beat in WAIT_HEAD. Required: the beat is dropped and o_err pulses.
- Reset mid-packet: assert i_rst_n=0 after the head plus 1 body beat. Required: all outputs are 0 immediately. After release, port 0 is granted first when ports 0 and 3 both request.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): port 0 is granted but sends nothing, while port 1 holds req. Required: o_timeout pulses 16 cycles after the grant, then port 1 is granted.
- Timeout disabled: repeat the previous scenario with ARB_TIMEOUT_EN undefined. Required: the grant to port 0 is held indefinitely (checked for 100 cycles) and o_timeout stays 0.

Source files
------------

// File: rtl/htd_rr_arbiter.sv
// Packet-level round-robin arbiter that shares one head/tail-framed channel among NUM_PORTS requesters.
// Define ARB_TIMEOUT_EN to revoke a grant whose head beat never arrives within TIMEOUT_CYCLES.
module htd_rr_arbiter #(
    parameter int NUM_PORTS      = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [NUM_PORTS-1:0]                iv_req,
    output logic [NUM_PORTS-1:0]                ov_gnt,
    input  logic [NUM_PORTS*(DATA_WIDTH+1)-1:0] iv_data,
    input  logic [NUM_PORTS-1:0]                iv_data_wr,
    output logic [DATA_WIDTH:0]                 ov_data,
    output logic                                o_data_wr,
    output logic                                o_err,
    output logic                                o_timeout
);

    localparam int BEAT_W = DATA_WIDTH + 1;
    localparam int PTR_W  = $clog2(NUM_PORTS);
    localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(NUM_PORTS - 1);

    typedef enum logic [1:0] {IDLE, WAIT_HEAD, BODY} state_t;

    if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("htd_rr_arbiter: NUM_PORTS must be 2..8 and TIMEOUT_CYCLES at least 1");
    end

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_PORTS-1:0] gnt_d;
    logic [DATA_WIDTH:0]  data_d;
    logic                 data_wr_d;
    logic                 err_d;

    logic [BEAT_W-1:0]    beats [NUM_PORTS];
    logic                 win_found;
    logic [PTR_W-1:0]     win_idx;
    logic [PTR_W-1:0]     cand;
    logic                 own_wr;
    logic                 own_flag;
    logic                 foreign_wr;

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_beat
        assign beats[k] = iv_data[k*BEAT_W +: BEAT_W];
    end

    // The pointer always names the granted port while a grant is held.
    assign own_wr     = (state_q != IDLE) && iv_data_wr[ptr_q];
    assign own_flag   = beats[ptr_q][DATA_WIDTH];
    assign foreign_wr = |(iv_data_wr & ~ov_gnt);

    // Search starts just past the last winner, wrapping, so the last winner ranks lowest.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = (cand == LAST_PORT) ? '0 : cand + 1'b1;
            if (!win_found && iv_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_d;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = ov_gnt;
        data_d    = ov_data;
        data_wr_d = 1'b0;
        err_d     = foreign_wr;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    ptr_d          = win_idx;
                    state_d        = WAIT_HEAD;
`ifdef ARB_TIMEOUT_EN
                    cnt_d          = '0;
`endif
                end
            end
            WAIT_HEAD: begin
                if (own_wr && own_flag) begin
                    data_d    = beats[ptr_q];
                    data_wr_d = 1'b1;
                    state_d   = BODY;
                end else begin
                    if (own_wr) begin
                        err_d = 1'b1;
                    end
`ifdef ARB_TIMEOUT_EN
                    // The pointer stays on the timed-out port, leaving it lowest priority.
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        gnt_d     = '0;
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            BODY: begin
                if (own_wr) begin
                    data_d    = beats[ptr_q];
                    data_wr_d = 1'b1;
                    if (own_flag) begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= LAST_PORT;
            ov_gnt    <= '0;
            ov_data   <= '0;
            o_data_wr <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            ov_gnt    <= gnt_d;
            ov_data   <= data_d;
            o_data_wr <= data_wr_d;
            o_err     <= err_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            o_timeout <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            o_timeout <= timeout_d;
        end
    end
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_htd_rr_arbiter.sv
// Self-checking bench for htd_rr_arbiter: a directed vector table plus hand-written
// sequences for fairness, mid-packet reset and head timeout (ARB_TIMEOUT_EN aware).
module tb_htd_rr_arbiter;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int W1 = DW + 1;
    localparam int TO = 16;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic [NP-1:0]     iv_req;
    logic [NP-1:0]     ov_gnt;
    logic [NP*W1-1:0]  iv_data;
    logic [NP-1:0]     iv_data_wr;
    logic [W1-1:0]     ov_data;
    logic              o_data_wr;
    logic              o_err;
    logic              o_timeout;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [NP-1:0]    req;
        logic [NP-1:0]    wr;
        logic [NP*W1-1:0] data;
        logic [NP-1:0]    gnt;
        logic [W1-1:0]    dout;
        logic             dwr;
        logic             err;
    } vec_t;

    vec_t vecs[$];

    htd_rr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .iv_req     (iv_req),
        .ov_gnt     (ov_gnt),
        .iv_data    (iv_data),
        .iv_data_wr (iv_data_wr),
        .ov_data    (ov_data),
        .o_data_wr  (o_data_wr),
        .o_err      (o_err),
        .o_timeout  (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NP*W1-1:0] put(input int port, input logic [W1-1:0] beat);
        logic [NP*W1-1:0] v;
        v = '0;
        v[port*W1 +: W1] = beat;
        return v;
    endfunction

    function automatic logic [NP-1:0] onehot(input int port);
        logic [NP-1:0] v;
        v = '0;
        v[port] = 1'b1;
        return v;
    endfunction

    // Drive one cycle of inputs, then sample just after the capturing edge.
    task automatic step(input logic [NP-1:0] req, input logic [NP-1:0] wr, input logic [NP*W1-1:0] data);
        iv_req     = req;
        iv_data_wr = wr;
        iv_data    = data;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        iv_req     = '0;
        iv_data_wr = '0;
        iv_data    = '0;
        i_rst_n    = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic add(input logic [NP-1:0] req, input logic [NP-1:0] wr, input logic [NP*W1-1:0] data,
                       input logic [NP-1:0] gnt, input logic [W1-1:0] dout, input logic dwr, input logic err);
        vecs.push_back('{req, wr, data, gnt, dout, dwr, err});
    endtask

    initial begin
        // Single 4-beat packet on port 1, then protocol errors on a port-0 packet.
        add(4'b0010, 4'b0000, '0,                                 4'b0010, 9'h000, 1'b0, 1'b0);
        add(4'b0010, 4'b0010, put(1, 9'h1A5),                     4'b0010, 9'h1A5, 1'b1, 1'b0);
        add(4'b0010, 4'b0010, put(1, 9'h011),                     4'b0010, 9'h011, 1'b1, 1'b0);
        add(4'b0010, 4'b0010, put(1, 9'h022),                     4'b0010, 9'h022, 1'b1, 1'b0);
        add(4'b0010, 4'b0010, put(1, 9'h1B6),                     4'b0000, 9'h1B6, 1'b1, 1'b0);
        add(4'b0000, 4'b0000, '0,                                 4'b0000, 9'h1B6, 1'b0, 1'b0);
        add(4'b0001, 4'b0000, '0,                                 4'b0001, 9'h1B6, 1'b0, 1'b0);
        add(4'b0000, 4'b0100, put(2, 9'h155),                     4'b0001, 9'h1B6, 1'b0, 1'b1);
        add(4'b0000, 4'b0001, put(0, 9'h033),                     4'b0001, 9'h1B6, 1'b0, 1'b1);
        add(4'b0000, 4'b0001, put(0, 9'h1C3),                     4'b0001, 9'h1C3, 1'b1, 1'b0);
        add(4'b0000, 4'b1001, put(0, 9'h1D4) | put(3, 9'h044),    4'b0000, 9'h1D4, 1'b1, 1'b1);
        add(4'b0000, 4'b0000, '0,                                 4'b0000, 9'h1D4, 1'b0, 1'b0);
        add(4'b0000, 4'b0010, put(1, 9'h012),                     4'b0000, 9'h1D4, 1'b0, 1'b1);
        add(4'b1111, 4'b0000, '0,                                 4'b0010, 9'h1D4, 1'b0, 1'b0);

        do_reset();
        check("reset gnt", ov_gnt, '0);
        check("reset data", ov_data, '0);
        check("reset data_wr", o_data_wr, 1'b0);
        check("reset err", o_err, 1'b0);
        check("reset timeout", o_timeout, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].req, vecs[i].wr, vecs[i].data);
            check($sformatf("vec%0d gnt", i), ov_gnt, vecs[i].gnt);
            check($sformatf("vec%0d data", i), ov_data, vecs[i].dout);
            check($sformatf("vec%0d data_wr", i), o_data_wr, vecs[i].dwr);
            check($sformatf("vec%0d err", i), o_err, vecs[i].err);
            check($sformatf("vec%0d timeout", i), o_timeout, 1'b0);
        end

        // Fairness: all ports request continuously, 2-beat packets, one idle cycle between packets.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            int p;
            p = k % NP;
            step(4'b1111, '0, '0);
            check($sformatf("fair%0d grant", k), ov_gnt, onehot(p));
            check($sformatf("fair%0d gap", k), o_data_wr, 1'b0);
            step(4'b1111, onehot(p), put(p, 9'h100 | 9'(8'h10 * p + k)));
            check($sformatf("fair%0d head", k), {o_data_wr, ov_data}, {1'b1, 9'h100 | 9'(8'h10 * p + k)});
            step(4'b1111, onehot(p), put(p, 9'h1F0 | 9'(p)));
            check($sformatf("fair%0d tail", k), {o_data_wr, ov_data}, {1'b1, 9'h1F0 | 9'(p)});
            check($sformatf("fair%0d release", k), ov_gnt, '0);
        end

        // Asynchronous reset after head plus one body beat.
        do_reset();
        step(4'b0001, '0, '0);
        check("rst_mid grant", ov_gnt, 4'b0001);
        step(4'b0001, 4'b0001, put(0, 9'h1AA));
        step(4'b0001, 4'b0001, put(0, 9'h055));
        check("rst_mid body", {o_data_wr, ov_data}, {1'b1, 9'h055});
        i_rst_n = 1'b0;
        #1;
        check("rst_mid outputs", {ov_gnt, ov_data, o_data_wr, o_err, o_timeout}, '0);
        @(negedge i_clk);
        i_rst_n    = 1'b1;
        iv_data_wr = '0;
        step(4'b1001, '0, '0);
        check("rst_mid regrant", ov_gnt, 4'b0001);

        // Port 0 granted but silent while port 1 keeps requesting.
        do_reset();
        step(4'b0011, '0, '0);
        check("stall grant", ov_gnt, 4'b0001);
`ifdef ARB_TIMEOUT_EN
        for (int c = 1; c < TO; c++) begin
            step(4'b0010, '0, '0);
            check($sformatf("stall c%0d gnt", c), ov_gnt, 4'b0001);
            check($sformatf("stall c%0d timeout", c), o_timeout, 1'b0);
        end
        step(4'b0010, '0, '0);
        check("timeout pulse", o_timeout, 1'b1);
        check("timeout revoke", ov_gnt, '0);
        step(4'b0010, '0, '0);
        check("timeout next grant", ov_gnt, 4'b0010);
        check("timeout pulse end", o_timeout, 1'b0);
`else
        for (int c = 1; c <= 100; c++) begin
            step(4'b0010, '0, '0);
            check($sformatf("hold c%0d gnt", c), ov_gnt, 4'b0001);
            check($sformatf("hold c%0d timeout", c), o_timeout, 1'b0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
